// File: rtl/cv32e40p_instr_encoder.sv
// ============================================================================
// Module  : cv32e40p_instr_encoder
// Purpose : Encodes RV32 field tuples into 32-bit words with an illegal-immediate
//           flag and buffers them in a small FIFO. Optional LFSR word source
//           enabled by the MCY_ENC_RANDOM_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_instr_encoder #(
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_fmt_i,
  input  logic [6:0]           req_opcode_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [6:0]           req_funct7_i,
  input  logic [4:0]           req_rd_i,
  input  logic [4:0]           req_rs1_i,
  input  logic [4:0]           req_rs2_i,
  input  logic [31:0]          req_imm_i,
  input  logic                 rnd_en_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_illegal_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic signed [31:0] imm_s;

  assign imm_s = $signed(req_imm_i);

  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    case (req_fmt_i)
      FMT_R: enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      FMT_I: begin
        enc_word    = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        enc_illegal = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        enc_word    = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i, req_imm_i[4:0], req_opcode_i};
        enc_illegal = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        enc_word    = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                       req_imm_i[4:1], req_imm_i[11], req_opcode_i};
        enc_illegal = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || req_imm_i[0];
      end
      FMT_U: begin
        enc_word    = {req_imm_i[31:12], req_rd_i, req_opcode_i};
        enc_illegal = (req_imm_i[11:0] != 12'h0);
      end
      FMT_J: begin
        enc_word    = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                       req_rd_i, req_opcode_i};
        enc_illegal = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || req_imm_i[0];
      end
      default: begin
        enc_word    = 32'h0;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [32:0]   mem [FIFO_DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [32:0]   push_data;
  logic [32:0]   head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && instr_ready_i;

`ifdef MCY_ENC_RANDOM_EN
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic        rnd_push;

  assign rnd_push    = rnd_en_i && !full;
  assign req_ready_o = !full && !rnd_en_i;
  assign push        = rnd_push || (req_valid_i && req_ready_o);
  assign push_data   = rnd_en_i ? {1'b0, lfsr[31:2], 2'b11} : {enc_illegal, enc_word};
  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  assign lfsr_next   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (rnd_push) begin
      lfsr <= lfsr_next;
    end
  end
`else
  logic unused_rnd_en;

  assign unused_rnd_en = rnd_en_i;
  assign req_ready_o   = !full;
  assign push          = req_valid_i && req_ready_o;
  assign push_data     = {enc_illegal, enc_word};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_o <= '0;
    end else if (pop) begin
      instr_cnt_o <= instr_cnt_o + 1'b1;
    end
  end

  assign head            = mem[rptr[AW-1:0]];
  assign instr_valid_o   = !empty;
  assign instr_rdata_o   = empty ? 32'h0 : head[31:0];
  assign instr_illegal_o = empty ? 1'b0 : head[32];

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_instr_encoder.sv
// Directed bench for cv32e40p_instr_encoder with a queue-based reference model.
`default_nettype none

module tb_cv32e40p_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fmt = '0;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        rnd_en = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_rdata;
  logic        instr_illegal;
  logic [15:0] instr_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b1;
  bit stream = 1'b0;

  logic [32:0] q[$];
  logic [15:0] mcnt = '0;

  cv32e40p_instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16), .LFSR_SEED(32'hACE1_2468)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fmt_i(req_fmt), .req_opcode_i(req_opcode), .req_funct3_i(req_funct3),
    .req_funct7_i(req_funct7), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_imm_i(req_imm), .rnd_en_i(rnd_en),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_rdata_o(instr_rdata), .instr_illegal_o(instr_illegal), .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from the field layout with plain shift/mask arithmetic.
  function automatic logic [32:0] model_enc(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
    longint s;
    logic [31:0] w;
    bit bad;
    s = longint'($signed(imm));
    w = 32'h0;
    bad = 1'b0;
    case (fmt)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      3'd1: begin
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
          | ((imm & 32'h1F) << 7) | 32'(op);
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
          | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
          | (((imm >> 11) & 32'h1) << 7) | 32'(op);
        bad = (s < -4096) || (s > 4094) || ((imm & 32'h1) != 0);
      end
      3'd4: begin
        w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
        bad = (imm & 32'hFFF) != 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
        bad = (s < -1048576) || (s > 1048574) || ((imm & 32'h1) != 0);
      end
      default: begin
        w = 32'h0;
        bad = 1'b1;
      end
    endcase
    return {bad, w};
  endfunction

  // Model update: occupancy is judged before the pop, so a full FIFO never accepts.
  initial begin
    bit do_pop, do_push;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        mcnt = '0;
      end else begin
        do_pop  = (q.size() > 0) && instr_ready;
        do_push = req_valid && (q.size() < DEPTH) && !rnd_en;
        if (do_pop) begin
          void'(q.pop_front());
          mcnt = mcnt + 16'd1;
        end
        if (do_push) q.push_back(model_enc(req_fmt, req_opcode, req_funct3, req_funct7,
                                           req_rd, req_rs1, req_rs2, req_imm));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && check_en) begin
        chk("valid", 32'(instr_valid), 32'(q.size() > 0));
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("cnt", 32'(instr_cnt), 32'(mcnt));
        if (q.size() > 0) begin
          chk("rdata", instr_rdata, q[0][31:0]);
          chk("illegal", 32'(instr_illegal), 32'(q[0][32]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stream) instr_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit done;
    done = 1'b0;
    req_fmt = fmt; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop1();
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
  endtask

  task automatic drain();
    instr_ready = 1'b1;
    for (int i = 0; i < 50 && instr_valid; i++) begin
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b0;
    chk("drain_empty", 32'(instr_valid), 32'd0);
  endtask

  task automatic expect_head(input string name, input logic [31:0] word, input bit chk_word, input bit ill);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    if (chk_word) chk({name, "_rdata"}, instr_rdata, word);
    chk({name, "_illegal"}, 32'(instr_illegal), 32'(ill));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rdata", instr_rdata, 32'h0);
    chk("rst_illegal", 32'(instr_illegal), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T5: fill, back-pressure, single pop
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2);
    chk("t5_full_ready", 32'(req_ready), 32'd0);
    pop1();
    chk("t5_ready_after_pop", 32'(req_ready), 32'd1);
    chk("t5_cnt", 32'(instr_cnt), 32'd1);
    drain();

    // T1
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    expect_head("t1", 32'h0051_0093, 1'b1, 1'b0);
    drain();

    // T2: ordering of R then U
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    expect_head("t2_r", 32'h0020_81B3, 1'b1, 1'b0);
    pop1();
    expect_head("t2_u", 32'h1234_52B7, 1'b1, 1'b0);
    drain();

    // T3: branch offset alignment
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd9);
    expect_head("t3_b8", 32'h0020_8463, 1'b1, 1'b0);
    pop1();
    expect_head("t3_b9", 32'h0, 1'b0, 1'b1);
    drain();

    // T4: I out of range, reserved format
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd4);
    expect_head("t4_i2048", 32'h8001_0093, 1'b1, 1'b1);
    pop1();
    expect_head("t4_fmt7", 32'h0, 1'b1, 1'b1);
    drain();

    // Boundary stream under random consumer back-pressure
    stream = 1'b1;
    send(3'd1, 7'h13, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, -32'sd2048);
    send(3'd1, 7'h03, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, -32'sd2049);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd9, 5'd10, 32'd2047);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd9, 5'd10, 32'd2048);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd11, 5'd12, 32'd4094);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd11, 5'd12, -32'sd4096);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd11, 5'd12, 32'd4096);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048574);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1048576);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    send(3'd4, 7'h17, 3'd0, 7'd0, 5'd31, 5'd0, 5'd0, 32'hFFFF_F001);
    send(3'd0, 7'h33, 3'd5, 7'h20, 5'd31, 5'd30, 5'd29, 32'hFFFF_FFFF);
    send(3'd6, 7'h33, 3'd5, 7'h20, 5'd31, 5'd30, 5'd29, 32'h0);
    stream = 1'b0;
    #1;
    drain();

    // T6: asynchronous reset with words queued
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd6);
    chk("t6_cnt_nonzero", 32'(instr_cnt != 16'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_cnt", 32'(instr_cnt), 32'd0);
    chk("t6_rdata", instr_rdata, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

`ifdef MCY_ENC_RANDOM_EN
    check_en = 1'b0;
    @(posedge clk);
    #1 rnd_en = 1'b1;
    chk("rnd_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    expect_head("rnd_first", 32'hACE1_246B, 1'b1, 1'b0);
    rnd_en = 1'b0;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    check_en = 1'b1;
`endif

    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_head("post_rst", 32'h0020_81B3, 1'b1, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
